// File: rtl/pdm_cic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pdm_cic_pkg
// Purpose  : Shared derivations and helpers for the PDM CIC decimator.
//            Width/shift derivation, the +1/-1 PDM mapping and a signed
//            saturation helper.
// Revision : 1.0 - initial release
// ============================================================================
package pdm_cic_pkg;

  // PDM bit mapping: logic 1 represents +1, logic 0 represents -1
  localparam logic signed [1:0] PDM_POS = 2'sd1;
  localparam logic signed [1:0] PDM_NEG = -2'sd1;

  // Working width for the output scaling/saturation path
  localparam int SAT_W = 64;

  typedef logic signed [SAT_W-1:0] wide_t;

  typedef struct packed {
    wide_t value;
    logic  clipped;
  } sat_res_t;

  // Bit growth of an ORDER-stage CIC decimating by 2**DEC_LOG2
  function automatic int cic_growth(input int order, input int dec_log2);
    return order * dec_log2;
  endfunction

  // Integrator/comb register width: growth plus sign and input bits
  function automatic int cic_acc_w(input int order, input int dec_log2);
    return cic_growth(order, dec_log2) + 2;
  endfunction

  // Right-shift that maps the filter output onto the PCM word;
  // negative means a left shift is needed instead
  function automatic int cic_shift(input int order, input int dec_log2, input int w_out);
    return cic_growth(order, dec_log2) + 1 - w_out;
  endfunction

  // Clip y to the signed range of a w-bit word and flag any clipping
  function automatic sat_res_t sat_signed(input wide_t y, input int w);
    wide_t    hi;
    wide_t    lo;
    sat_res_t r;
    hi        = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo        = -hi - wide_t'(1);
    r.value   = y;
    r.clipped = 1'b0;
    if (y > hi) begin
      r.value   = hi;
      r.clipped = 1'b1;
    end else if (y < lo) begin
      r.value   = lo;
      r.clipped = 1'b1;
    end
    return r;
  endfunction

endpackage : pdm_cic_pkg
`default_nettype wire

// File: rtl/pdm_cic_integrator.sv
`default_nettype none
// ============================================================================
// Module   : pdm_cic_integrator
// Purpose  : One CIC integrator stage: an ACC_W-bit accumulator that adds
//            its input on enabled cycles and wraps modulo 2**ACC_W.
// Revision : 1.0 - initial release
// ============================================================================
module pdm_cic_integrator
  import pdm_cic_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [ACC_W-1:0] add_i,
  output logic [ACC_W-1:0] acc_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  // Accumulate on accepted samples only; overflow wraps by design
  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      acc_d = acc_q + add_i;
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule : pdm_cic_integrator
`default_nettype wire

// File: rtl/pdm_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module   : pdm_cic_decimator
// Purpose  : ORDER-stage CIC (sinc^N) decimator turning a 1-bit PDM stream
//            into signed W_OUT-bit PCM words, decimating by 2**DEC_LOG2,
//            with saturating output scaling and a warm-up blanking period.
// Options  : PDM_CIC_ROUND_EN - round half up before the output right shift
//            (default build truncates).
// Revision : 1.0 - initial release
// ============================================================================
module pdm_cic_decimator
  import pdm_cic_pkg::*;
#(
  parameter int W_OUT    = 16,
  parameter int ORDER    = 3,
  parameter int DEC_LOG2 = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pdm_in,
  input  logic                    pdm_en,
  output logic signed [W_OUT-1:0] pcm_out,
  output logic                    pcm_valid,
  output logic                    pcm_sat
);

  localparam int ACC_W  = cic_acc_w(ORDER, DEC_LOG2);
  localparam int SHIFT  = cic_shift(ORDER, DEC_LOG2, W_OUT);
  localparam int SHR    = (SHIFT > 0) ? SHIFT : 0;
  localparam int SHL    = (SHIFT < 0) ? -SHIFT : 0;
  localparam int WARM_W = $clog2(ORDER + 1);

`ifdef PDM_CIC_ROUND_EN
  // Half an output LSB, zero when no right shift is applied
  localparam wide_t RND = (wide_t'(1) <<< SHR) >>> 1;
`else
  localparam wide_t RND = '0;
`endif

  // --------------------------------------------------------------------------
  // Input mapping and decimation counter
  // --------------------------------------------------------------------------
  logic [ACC_W-1:0]    x_ext;
  logic [DEC_LOG2-1:0] cnt_q;
  logic [DEC_LOG2-1:0] cnt_d;
  logic                tick;
  logic                tick_q;

  assign x_ext = pdm_in ? ACC_W'(PDM_POS) : ACC_W'(PDM_NEG);

  // The R-th accepted sample of a frame triggers the comb/output pipeline
  assign tick = pdm_en && (cnt_q == '1);

  // Counter advances per accepted sample and wraps naturally after R-1
  always_comb begin
    cnt_d = cnt_q;
    if (pdm_en) begin
      cnt_d = cnt_q + DEC_LOG2'(1);
    end
  end

  // Counter and tick-delay registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick;
    end
  end

  // --------------------------------------------------------------------------
  // Integrator cascade: each stage adds the previous stage's registered value
  // --------------------------------------------------------------------------
  logic [ACC_W-1:0] int_acc [ORDER];

  for (genvar k = 0; k < ORDER; k++) begin : g_int
    if (k == 0) begin : g_first
      pdm_cic_integrator #(
        .ACC_W (ACC_W)
      ) u_int (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (pdm_en),
        .add_i (x_ext),
        .acc_o (int_acc[k])
      );
    end else begin : g_next
      pdm_cic_integrator #(
        .ACC_W (ACC_W)
      ) u_int (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (pdm_en),
        .add_i (int_acc[k-1]),
        .acc_o (int_acc[k])
      );
    end
  end

  // --------------------------------------------------------------------------
  // Comb chain, evaluated in the cycle after a tick
  // --------------------------------------------------------------------------
  logic [ACC_W-1:0]        dly_q [ORDER];
  logic [ACC_W-1:0]        dly_d [ORDER];
  logic signed [ACC_W-1:0] comb_last;

  // Differentiate the decimated integrator output; delays capture stage inputs
  always_comb begin
    logic [ACC_W-1:0] stage;
    stage = int_acc[ORDER-1];
    for (int k = 0; k < ORDER; k++) begin
      dly_d[k] = tick_q ? stage : dly_q[k];
      stage    = stage - dly_q[k];
    end
    comb_last = stage;
  end

  // Comb delay registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ORDER; k++) begin
        dly_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < ORDER; k++) begin
        dly_q[k] <= dly_d[k];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output scaling and saturation
  // --------------------------------------------------------------------------
  wide_t    comb_wide;
  wide_t    scaled;
  sat_res_t sat_res;
  logic     unused_hi;

  // Sign-extend, optionally round, shift onto the PCM scale, then clip
  always_comb begin
    comb_wide = wide_t'(comb_last);
    scaled    = ((comb_wide + RND) >>> SHR) <<< SHL;
    sat_res   = sat_signed(scaled, W_OUT);
  end

  // Bits above the PCM word are always a sign copy after clipping
  assign unused_hi = ^sat_res.value[SAT_W-1:W_OUT];

  // --------------------------------------------------------------------------
  // Warm-up blanking and output registers
  // --------------------------------------------------------------------------
  logic [WARM_W-1:0]       warm_q;
  logic [WARM_W-1:0]       warm_d;
  logic signed [W_OUT-1:0] pcm_out_q;
  logic signed [W_OUT-1:0] pcm_out_d;
  logic                    pcm_valid_q;
  logic                    pcm_valid_d;
  logic                    pcm_sat_q;
  logic                    pcm_sat_d;

  // The first ORDER frames only prime the comb delays; later frames publish
  always_comb begin
    warm_d      = warm_q;
    pcm_out_d   = pcm_out_q;
    pcm_valid_d = 1'b0;
    pcm_sat_d   = pcm_sat_q;
    if (tick_q) begin
      if (warm_q != WARM_W'(ORDER)) begin
        warm_d = warm_q + WARM_W'(1);
      end else begin
        pcm_out_d   = sat_res.value[W_OUT-1:0];
        pcm_valid_d = 1'b1;
        pcm_sat_d   = sat_res.clipped;
      end
    end
  end

  // Output and warm-up registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_q      <= '0;
      pcm_out_q   <= '0;
      pcm_valid_q <= 1'b0;
      pcm_sat_q   <= 1'b0;
    end else begin
      warm_q      <= warm_d;
      pcm_out_q   <= pcm_out_d;
      pcm_valid_q <= pcm_valid_d;
      pcm_sat_q   <= pcm_sat_d;
    end
  end

  assign pcm_out   = pcm_out_q;
  assign pcm_valid = pcm_valid_q;
  assign pcm_sat   = pcm_sat_q;

endmodule : pdm_cic_decimator
`default_nettype wire
